// File: rtl/echo_pkg.sv
// Shared types, widths and helpers for the echo tap scheduler.
package echo_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecord,
        StIssue,
        StDrain,
        StEmit
    } state_e;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned ACC_W    = 12;
    localparam int unsigned DELAY_W  = 16;

    localparam int SAMPLE_MAX = 2 ** (SAMPLE_W - 1) - 1;
    localparam int SAMPLE_MIN = -(2 ** (SAMPLE_W - 1));

    // (p - d) mod len for p < len; one extra bit catches the borrow
    function automatic logic [31:0] addr_mod_sub(input logic [31:0] p, input logic [31:0] d,
                                                 input logic [31:0] len);
        logic [32:0] diff;
        diff = {1'b0, p} - {1'b0, d};
        if (diff[32]) begin
            diff = diff + {1'b0, len};
        end
        return diff[31:0];
    endfunction

    function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic signed [ACC_W-1:0] a);
        int v;
        v = int'(a);
        if (v > SAMPLE_MAX) begin
            v = SAMPLE_MAX;
        end else if (v < SAMPLE_MIN) begin
            v = SAMPLE_MIN;
        end
        return SAMPLE_W'(v);
    endfunction

endpackage

// File: rtl/tap_mixer.sv
// Tracks in-flight tap reads, accumulates each returning word scaled by 2^-k,
// and registers the clamped mix when the scheduler signals the final cycle.
module tap_mixer
    import echo_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned TAP_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                tag_valid_i,
    input  logic [TAP_W-1:0]    tag_idx_i,
    input  logic [SAMPLE_W-1:0] rd_data_i,
    input  logic                emit_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o
);

    logic [RD_LAT-1:0]        tag_v_q;
    logic [TAP_W-1:0]         tag_k_q [RD_LAT];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  ext, contrib;
    logic [SAMPLE_W-1:0]      sample_q;
    logic                     valid_q;

    always_comb begin
        ext     = {{(ACC_W - SAMPLE_W){rd_data_i[SAMPLE_W-1]}}, rd_data_i};
        contrib = ext >>> tag_k_q[RD_LAT-1];
        acc_d   = acc_q;
        if (tag_v_q[RD_LAT-1]) begin
            acc_d = acc_q + contrib;
        end
    end

    // Tag stage RD_LAT-1 lines up with the data word returned for that read
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            tag_v_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_k_q[i] <= '0;
            end
            acc_q <= '0;
        end else begin
            tag_v_q[0] <= tag_valid_i;
            tag_k_q[0] <= tag_idx_i;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_k_q[i] <= tag_k_q[i-1];
            end
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= emit_i;
            if (emit_i) begin
                sample_q <= clamp_sample(acc_d);
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;

endmodule

// File: rtl/echo_tap_scheduler.sv
// Record/playback controller for a dual-port sample buffer with delayed echo taps.
// Define ECHO_FEEDBACK_EN to write each mixed sample back over the played address.
module echo_tap_scheduler
    import echo_pkg::*;
#(
    parameter int unsigned DEPTH    = 18000,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned NUM_TAPS = 3,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [SAMPLE_W-1:0]             audio_in,
    input  logic                            audio_valid_in,
    input  logic                            record_in,
    input  logic [(NUM_TAPS-1)*DELAY_W-1:0] tap_delay_in,
    output logic                            ram_we,
    output logic [ADDR_W-1:0]               ram_wr_addr,
    output logic [SAMPLE_W-1:0]             ram_din,
    output logic [ADDR_W-1:0]               ram_rd_addr,
    input  logic [SAMPLE_W-1:0]             ram_rd_data,
    output logic [SAMPLE_W-1:0]             sample_out,
    output logic                            sample_out_valid,
    output logic [ADDR_W-1:0]               rec_length,
    output logic                            full,
    output logic                            overrun
);

    localparam int unsigned TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned DRN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e                            state_q, state_d;
    logic                              rec_q;
    logic [ADDR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]                 play_ptr_q, play_ptr_d;
    logic [ADDR_W-1:0]                 p_q, p_d;
    logic [ADDR_W-1:0]                 rec_len_q, rec_len_d;
    logic                              full_q, full_d;
    logic                              overrun_q, overrun_d;
    logic [(NUM_TAPS-1)*DELAY_W-1:0]   delays_q, delays_d;
    logic [TAP_W-1:0]                  tap_q, tap_d;
    logic [DRN_W-1:0]                  drn_q, drn_d;
    logic [ADDR_W-1:0]                 rd_addr_q;
    logic                              we_q, we_d;
    logic [ADDR_W-1:0]                 wr_addr_q, wr_addr_d;
    logic [SAMPLE_W-1:0]               din_q, din_d;

    logic                              rec_rise, rec_fall;
    logic                              clear_mix, tag_valid, emit;
    logic [DELAY_W-1:0]                d_k;
    logic                              skip;
    logic [ADDR_W-1:0]                 issue_addr;

    assign rec_rise = record_in & ~rec_q;
    assign rec_fall = ~record_in & rec_q;

    always_comb begin
        d_k = '0;
        for (int unsigned i = 1; i < NUM_TAPS; i++) begin
            if (tap_q == TAP_W'(i)) begin
                d_k = delays_q[(i-1)*DELAY_W +: DELAY_W];
            end
        end
    end

    assign skip        = 32'(d_k) >= 32'(rec_len_q);
    assign issue_addr  = ADDR_W'(addr_mod_sub(32'(p_q), 32'(d_k), 32'(rec_len_q)));
    // Skipped taps leave the read address parked on its previous value
    assign ram_rd_addr = (state_q == StIssue && !skip) ? issue_addr : rd_addr_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        play_ptr_d = play_ptr_q;
        p_d        = p_q;
        rec_len_d  = rec_len_q;
        full_d     = full_q;
        overrun_d  = overrun_q;
        delays_d   = delays_q;
        tap_d      = tap_q;
        drn_d      = drn_q;
        we_d       = 1'b0;
        wr_addr_d  = wr_addr_q;
        din_d      = din_q;
        clear_mix  = 1'b0;
        tag_valid  = 1'b0;
        emit       = 1'b0;

        if (rec_rise) begin
            state_d   = StRecord;
            wr_ptr_d  = '0;
            full_d    = 1'b0;
            clear_mix = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (audio_valid_in && !record_in && rec_len_q != '0) begin
                        state_d    = StIssue;
                        delays_d   = tap_delay_in;
                        p_d        = play_ptr_q;
                        play_ptr_d = (play_ptr_q == rec_len_q - ADDR_W'(1)) ? '0
                                                                            : play_ptr_q + 1'b1;
                        tap_d      = '0;
                        clear_mix  = 1'b1;
                    end
                end
                StRecord: begin
                    if (rec_fall) begin
                        state_d    = StIdle;
                        rec_len_d  = wr_ptr_q;
                        play_ptr_d = '0;
                    end else if (audio_valid_in && 32'(wr_ptr_q) < DEPTH) begin
                        we_d      = 1'b1;
                        wr_addr_d = wr_ptr_q;
                        din_d     = audio_in;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        if (32'(wr_ptr_q) == DEPTH - 1) begin
                            full_d = 1'b1;
                        end
                    end
                end
                StIssue: begin
                    tag_valid = !skip;
                    tap_d     = tap_q + 1'b1;
                    if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                        state_d = StDrain;
                        drn_d   = '0;
                    end
                end
                StDrain: begin
                    if (drn_q == DRN_W'(RD_LAT - 1)) begin
                        emit    = 1'b1;
                        state_d = StEmit;
                    end else begin
                        drn_d = drn_q + 1'b1;
                    end
                end
                StEmit: begin
                    state_d = StIdle;
`ifdef ECHO_FEEDBACK_EN
                    we_d      = 1'b1;
                    wr_addr_d = p_q;
                    din_d     = sample_out;
`endif
                end
                default: state_d = StIdle;
            endcase

            if (audio_valid_in &&
                (state_q == StIssue || state_q == StDrain || state_q == StEmit)) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            rec_q      <= 1'b0;
            wr_ptr_q   <= '0;
            play_ptr_q <= '0;
            p_q        <= '0;
            rec_len_q  <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            delays_q   <= '0;
            tap_q      <= '0;
            drn_q      <= '0;
            rd_addr_q  <= '0;
            we_q       <= 1'b0;
            wr_addr_q  <= '0;
            din_q      <= '0;
        end else begin
            state_q    <= state_d;
            rec_q      <= record_in;
            wr_ptr_q   <= wr_ptr_d;
            play_ptr_q <= play_ptr_d;
            p_q        <= p_d;
            rec_len_q  <= rec_len_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            delays_q   <= delays_d;
            tap_q      <= tap_d;
            drn_q      <= drn_d;
            rd_addr_q  <= ram_rd_addr;
            we_q       <= we_d;
            wr_addr_q  <= wr_addr_d;
            din_q      <= din_d;
        end
    end

    tap_mixer #(
        .RD_LAT (RD_LAT),
        .TAP_W  (TAP_W)
    ) u_tap_mixer (
        .clk_i          (clk_in),
        .rst_i          (rst_in),
        .clear_i        (clear_mix),
        .tag_valid_i    (tag_valid),
        .tag_idx_i      (tap_q),
        .rd_data_i      (ram_rd_data),
        .emit_i         (emit),
        .sample_o       (sample_out),
        .sample_valid_o (sample_out_valid)
    );

    assign ram_we      = we_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_din     = din_q;
    assign rec_length  = rec_len_q;
    assign full        = full_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// Directed bench for echo_tap_scheduler with a 2-cycle-latency dual-port RAM model.
module tb_echo_tap_scheduler;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [7:0]  audio_in;
    logic        audio_valid_in;
    logic        record_in;
    logic [31:0] tap_delay_in;
    logic        ram_we;
    logic [14:0] ram_wr_addr;
    logic [7:0]  ram_din;
    logic [14:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [7:0]  sample_out;
    logic        sample_out_valid;
    logic [14:0] rec_length;
    logic        full;
    logic        overrun;

    echo_tap_scheduler dut (
        .clk_in           (clk),
        .rst_in           (rst_in),
        .audio_in         (audio_in),
        .audio_valid_in   (audio_valid_in),
        .record_in        (record_in),
        .tap_delay_in     (tap_delay_in),
        .ram_we           (ram_we),
        .ram_wr_addr      (ram_wr_addr),
        .ram_din          (ram_din),
        .ram_rd_addr      (ram_rd_addr),
        .ram_rd_data      (ram_rd_data),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .rec_length       (rec_length),
        .full             (full),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32768];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_din;
        rd1 <= mem[ram_rd_addr];
        rd2 <= rd1;
    end
    assign ram_rd_data = rd2;

    int wr_cnt = 0;
    int last_wr_addr = -1;
    int last_wr_data = -1;
    always @(negedge clk) begin
        if (ram_we) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= int'(ram_wr_addr);
            last_wr_data <= int'(ram_din);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [7:0] sval(input int mode, input int i);
        if (mode == 0) return 8'(i);
        if (mode == 1) return 8'd127;
        return 8'(10 * (i + 1));
    endfunction

    task automatic record_samples(input int n, input int mode);
        @(posedge clk); #1 record_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 audio_in = sval(mode, i); audio_valid_in = 1'b1;
            if (i == n / 2 + 1) begin
                @(negedge clk);
                chk("rec_we", int'(ram_we), 1);
                chk("rec_addr", int'(ram_wr_addr), i - 1);
                chk("rec_din", int'(ram_din), int'(sval(mode, i - 1)));
            end
        end
        @(posedge clk); #1 audio_valid_in = 1'b0; record_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic play(input logic [15:0] d1, input logic [15:0] d2, output int a0,
                        output int a1, output int a2, output int lat, output int out,
                        output int after);
        @(posedge clk); #1 tap_delay_in = {d2, d1}; audio_valid_in = 1'b1;
        @(posedge clk); #1 audio_valid_in = 1'b0;
        @(negedge clk); a0 = int'(ram_rd_addr);
        @(negedge clk); a1 = int'(ram_rd_addr);
        @(negedge clk); a2 = int'(ram_rd_addr);
        lat = 3;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (sample_out_valid) break;
        end
        out = int'($signed(sample_out));
        @(negedge clk);
        after = int'(sample_out_valid);
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sample_out_valid) cnt++;
        end
    endtask

    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        int          a0;
        int          a1;
        int          a2;
        int          out;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int a0, a1, a2, lat, out, after, cnt, w0;

        // Ramp buffer 0..99, play pointer p = 0..5 in order
        vecs[0] = '{16'd10,  16'd20,  0, 90, 80, 65};
        vecs[1] = '{16'd1,   16'd2,   1,  0, 99, 25};
        vecs[2] = '{16'd150, 16'd5,   2,  2, 97, 26};
        vecs[3] = '{16'd3,   16'd99,  3,  0,  4,  4};
        vecs[4] = '{16'd0,   16'd0,   4,  4,  4,  7};
        vecs[5] = '{16'd100, 16'd100, 5,  5,  5,  5};

        for (int i = 0; i < 32768; i++) mem[i] = 8'd0;
        rst_in = 1'b1; audio_in = '0; audio_valid_in = 1'b0; record_in = 1'b0;
        tap_delay_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        @(negedge clk);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_wr_addr", int'(ram_wr_addr), 0);
        chk("rst_din", int'(ram_din), 0);
        chk("rst_rd_addr", int'(ram_rd_addr), 0);
        chk("rst_sample", int'(sample_out), 0);
        chk("rst_valid", int'(sample_out_valid), 0);
        chk("rst_rec_length", int'(rec_length), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Nothing recorded yet: playback stays disabled
        @(posedge clk); #1 audio_valid_in = 1'b1;
        @(posedge clk); #1 audio_valid_in = 1'b0;
        count_valid(10, cnt);
        chk("empty_no_play", cnt, 0);

        record_samples(100, 0);
        chk("ramp_rec_length", int'(rec_length), 100);
        chk("ramp_full", int'(full), 0);

        for (int i = 0; i < 6; i++) begin
            play(vecs[i].d1, vecs[i].d2, a0, a1, a2, lat, out, after);
            chk($sformatf("vec%0d_a0", i), a0, vecs[i].a0);
            chk($sformatf("vec%0d_a1", i), a1, vecs[i].a1);
            chk($sformatf("vec%0d_a2", i), a2, vecs[i].a2);
            chk($sformatf("vec%0d_latency", i), lat, 6);
            chk($sformatf("vec%0d_out", i), out, vecs[i].out);
            chk($sformatf("vec%0d_pulse", i), after, 0);
        end
        chk("no_overrun_yet", int'(overrun), 0);

        // Second strobe lands three cycles in, while taps are still issuing
        @(posedge clk); #1 tap_delay_in = {16'd20, 16'd10}; audio_valid_in = 1'b1;
        @(posedge clk); #1 audio_valid_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 audio_valid_in = 1'b1;
        @(posedge clk); #1 audio_valid_in = 1'b0;
        lat = 3;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (sample_out_valid) break;
        end
        chk("ovr_latency", lat, 6);
        chk("ovr_out", int'($signed(sample_out)), 75);
        count_valid(10, cnt);
        chk("ovr_no_extra", cnt, 0);
        chk("ovr_flag", int'(overrun), 1);

        record_samples(100, 1);
        play(16'd1, 16'd2, a0, a1, a2, lat, out, after);
        chk("clamp_a1", a1, 99);
        chk("clamp_a2", a2, 98);
        chk("clamp_latency", lat, 6);
        chk("clamp_out", out, 127);

        // Three-sample loop, both echo taps out of range
        record_samples(3, 2);
        chk("wrap_rec_length", int'(rec_length), 3);
        for (int i = 0; i < 4; i++) begin
            play(16'd5, 16'd5, a0, a1, a2, lat, out, after);
            chk($sformatf("wrap%0d_a0", i), a0, i % 3);
            chk($sformatf("wrap%0d_out", i), out, 10 * (i % 3 + 1));
            chk($sformatf("wrap%0d_hold", i), a2, i % 3);
        end

        // Reset while the sequence is draining
        @(posedge clk); #1 tap_delay_in = {16'd5, 16'd5}; audio_valid_in = 1'b1;
        @(posedge clk); #1 audio_valid_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_in = 1'b1;
        @(posedge clk); #1 rst_in = 1'b0;
        @(negedge clk);
        chk("drain_rst_outs",
            int'({ram_we, ram_wr_addr, ram_din, ram_rd_addr, sample_out, sample_out_valid,
                  rec_length[7:0], full, overrun}) | int'(rec_length), 0);
        count_valid(10, cnt);
        chk("drain_rst_no_valid", cnt, 0);

        @(posedge clk); #1;
        w0 = wr_cnt;
        record_samples(18005, 0);
        chk("full_flag", int'(full), 1);
        chk("full_rec_length", int'(rec_length), 18000);
        chk("full_write_count", wr_cnt - w0, 18000);
        chk("full_last_addr", last_wr_addr, 17999);

        w0 = wr_cnt;
        play(16'd1, 16'd17999, a0, a1, a2, lat, out, after);
        chk("big_a0", a0, 0);
        chk("big_a1", a1, 17999);
        chk("big_a2", a2, 1);
        chk("big_out", out, 39);
        @(posedge clk); #1;
`ifdef ECHO_FEEDBACK_EN
        chk("fb_addr", last_wr_addr, 0);
        chk("fb_data", last_wr_data, 39);
`else
        chk("no_fb_write", wr_cnt - w0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/echo_tap_scheduler.md
Name: echo_tap_scheduler

Overview:
- Controller that owns both ports of the audio sample buffer, an external true-dual-port RAM, 8-bit wide with a 2-cycle read latency.
- Record: writes incoming samples sequentially and latches the recording length.
- Playback: on each audio strobe, advances a looping play pointer and issues NUM_TAPS sequenced reads at configurable delays, then mixes the attenuated taps into one output sample.
- Sits between the audio sampler and the PWM/output stage.

Parameters:
- DEPTH, 18000, buffer depth in samples.
- ADDR_W, 15, address width; must satisfy 2^ADDR_W >= DEPTH.
- NUM_TAPS, 3, number of read taps. Tap 0 is the dry sample at delay 0.
- RD_LAT, 2, RAM read latency in cycles.

Ports:
- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  synchronous, active-high reset.
- audio_in  in  8  signed sample to record.
- audio_valid_in  in  1  one-cycle sample strobe.
- record_in  in  1  level; high = record mode.
- tap_delay_in  in  (NUM_TAPS-1)*16  delays for taps 1..NUM_TAPS-1, in samples; sampled at sequence start.
- ram_we  out  1  port A write enable.
- ram_wr_addr  out  ADDR_W  port A address.
- ram_din  out  8  port A write data.
- ram_rd_addr  out  ADDR_W  port B address.
- ram_rd_data  in  8  port B data, valid RD_LAT cycles after the address.
- sample_out  out  8  signed mixed sample.
- sample_out_valid  out  1  one-cycle strobe.
- rec_length  out  ADDR_W  samples in the last completed recording.
- full  out  1  sticky; set when a recording hit DEPTH.
- overrun  out  1  sticky; set when a strobe arrives while a sequence is busy.

Behaviour:
- Reset: all outputs 0. State IDLE, pointers 0, rec_length 0, flags clear. A reset mid-sequence discards any in-flight reads; no valid pulse is produced.
- States: IDLE, RECORD, ISSUE, DRAIN, EMIT.
- Any state to RECORD: on a record_in rising edge.
  - wr_ptr <= 0 and full <= 0.
  - Any pending sequence is aborted; returning data is ignored.
- RECORD, on each audio_valid_in:
  - ram_we=1, ram_wr_addr=wr_ptr, ram_din=audio_in, all registered (one-cycle pulse); wr_ptr++.
  - When wr_ptr reaches DEPTH, further writes are suppressed and full <= 1.
- RECORD to IDLE: on record_in falling edge.
  - rec_length <= wr_ptr; play_ptr <= 0.
  - If wr_ptr == 0, playback stays disabled.
- IDLE to ISSUE: on audio_valid_in with record_in=0 and rec_length>0.
  - Latch the tap delays; clear the accumulator.
  - play_ptr advances modulo rec_length; it wraps to 0 after rec_length-1. The sequence uses the pre-increment value p.
- ISSUE: one read per cycle, for tap k = 0..NUM_TAPS-1.
  - Address = (p - d_k) mod rec_length, with d_0 = 0.
  - Subtraction is done at ADDR_W+1 bits; add rec_length if the result is negative.
  - A tap with d_k >= rec_length is skipped: no read is issued and it contributes 0.
- DRAIN: wait RD_LAT cycles after the last issue.
  - Each returning word is sign-extended to 12 bits, arithmetic-shifted right by k, and accumulated.
  - A tag pipeline RD_LAT deep tracks the tap index and valid bit of each read.
- EMIT: present sample_out = accumulator clamped to [-128, 127]; pulse sample_out_valid for one cycle; return to IDLE.
- Latency: sample_out_valid is asserted exactly NUM_TAPS+RD_LAT+1 cycles after the triggering audio_valid_in (6 cycles with defaults), regardless of skipped taps.
- audio_valid_in while not in IDLE (and not recording): the strobe is dropped and overrun <= 1.
- Port B is never written. ram_rd_addr holds its last value when idle.

Optional Feature:
- Macro: ECHO_FEEDBACK_EN.
- Defined:
  - On EMIT, the clamped sample_out is also written back to port A at address p (ram_we=1), so echoes regenerate.
  - If a record_in rising edge occurs in the same cycle, the record write wins.
- Undefined: port A writes only in RECORD; the buffer is read-only during playback.

Decomposition:
- Package echo_pkg holds:
  - state enum (IDLE, RECORD, ISSUE, DRAIN, EMIT);
  - SAMPLE_W=8 and ACC_W=12;
  - a function for the modular address subtract.
- One sub-module, tap_mixer: tag pipeline, shift/accumulate and clamp. It takes read-tag and data inputs and produces the sample outputs.

Test Plan:
- Record ramp 0..99 (100 strobes), release record, delays {10,20}, first playback strobe → reads at 0, 90, 80; sample_out = 0 + (90>>>1) + (80>>>2) = 45+20 = 65; valid 6 cycles after strobe; rec_length=100.
- Record 100 samples all 127, delays {1,2} → sample_out clamps to 127 (127+63+31=221).
- Delays {150,5}, rec_length=100 → tap 1 skipped, no read for it; latency still 6.
- Second strobe 3 cycles after the first → no extra output, overrun=1, first result still correct.
- Record 18005 strobes → writes stop at 17999, full=1, rec_length=18000. Then 18001 playback strobes → play_ptr wraps to 0 and then to 1.
- rst_in asserted during DRAIN → no sample_out_valid; all outputs 0 the following cycle. With ECHO_FEEDBACK_EN, EMIT writes sample_out to address p.
